// File: rtl/fortuna_pkg.sv
// Shared Fortuna widths and the reseed controller state encoding.
// Also used by the pool accumulator and the AES generator.
package fortuna_pkg;

    localparam int unsigned KEY_W        = 256;
    localparam int unsigned CTR_W        = 128;
    localparam int unsigned RESEED_CNT_W = 32;

    // Cycles spent in WAIT_LOW before assuming the hash core never drops ready.
    localparam int unsigned WAIT_LOW_MAX = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitLow,
        StWaitHash
    } reseed_state_e;

endpackage

// File: rtl/fortuna_ctr128.sv
// Fortuna block counter: increments modulo 2^128 but skips 0, which marks "unseeded".
module fortuna_ctr128
    import fortuna_pkg::*;
#(
    parameter logic [CTR_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CTR_W-1:0] ctr
);

    logic [CTR_W-1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (inc) begin
            ctr_d = ctr_q + CTR_W'(1);
            if (ctr_d == '0) begin
                ctr_d = CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q <= RESET_VAL;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr = ctr_q;

endmodule

// File: rtl/fortuna_reseed_ctrl.sv
// Fortuna reseed controller: drives sha256d, installs the new key, serves AES block counters.
// Define RESEED_TIMER_EN to enforce MIN_RESEED_CYCLES between accepted reseeds.
module fortuna_reseed_ctrl
    import fortuna_pkg::*;
#(
    parameter int unsigned MIN_RESEED_CYCLES = 1000,
    parameter int unsigned TIMER_W           = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reseed_req,
    input  logic [KEY_W-1:0]        seed_material,
    output logic                    reseed_done,
    output logic                    reseed_reject,
    output logic                    sha_init,
    output logic [KEY_W-1:0]        sha_clear_input,
    input  logic                    sha_ready,
    input  logic [KEY_W-1:0]        sha_hash,
    input  logic                    sha_hash_valid,
    input  logic                    blk_req,
    output logic                    blk_ack,
    output logic [KEY_W-1:0]        key,
    output logic [CTR_W-1:0]        ctr,
    output logic                    seeded,
    output logic [RESEED_CNT_W-1:0] reseed_cnt,
    output logic                    busy
);

    reseed_state_e           state_q, state_d;
    logic [KEY_W-1:0]        key_q, clear_q, clear_d;
    logic [RESEED_CNT_W-1:0] cnt_q;
    logic [1:0]              wait_cnt_q, wait_cnt_d;
    logic                    seeded_q, done_q, reject_q, reject_d, ack_q, ack_d;
    logic                    install, timer_expired;

`ifdef RESEED_TIMER_EN
    logic [TIMER_W-1:0] timer_q;

    assign timer_expired = (timer_q >= TIMER_W'(MIN_RESEED_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= TIMER_W'(MIN_RESEED_CYCLES);
        end else if (install) begin
            timer_q <= '0;
        end else if (!timer_expired) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end
`else
    logic unused_timer_cfg;

    assign unused_timer_cfg = (TIMER_W == 0) || (MIN_RESEED_CYCLES == 0);
    assign timer_expired    = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        clear_d    = clear_q;
        wait_cnt_d = wait_cnt_q;
        reject_d   = 1'b0;
        ack_d      = 1'b0;
        install    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A pending reseed request always takes priority over a block request.
                if (reseed_req) begin
                    if (sha_ready && timer_expired) begin
                        clear_d = key_q ^ seed_material;
                        state_d = StLaunch;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (blk_req && seeded_q && !ack_q) begin
                    ack_d = 1'b1;
                end
            end
            StLaunch: begin
                wait_cnt_d = '0;
                state_d    = StWaitLow;
            end
            StWaitLow: begin
                wait_cnt_d = wait_cnt_q + 2'd1;
                if (!sha_ready || (wait_cnt_q == 2'(WAIT_LOW_MAX - 1))) begin
                    state_d = StWaitHash;
                end
            end
            StWaitHash: begin
                if (sha_ready && sha_hash_valid) begin
                    install = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
        if (reseed_req && (state_q != StIdle)) begin
            reject_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            clear_q    <= '0;
            wait_cnt_q <= '0;
            key_q      <= '0;
            cnt_q      <= '0;
            seeded_q   <= 1'b0;
            done_q     <= 1'b0;
            reject_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clear_q    <= clear_d;
            wait_cnt_q <= wait_cnt_d;
            done_q     <= install;
            reject_q   <= reject_d;
            ack_q      <= ack_d;
            if (install) begin
                key_q    <= sha_hash;
                seeded_q <= 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + RESEED_CNT_W'(1);
                end
            end
        end
    end

    // The counter advances on key install and in the cycle after each block ack.
    fortuna_ctr128 u_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (install | ack_q),
        .ctr   (ctr)
    );

    assign reseed_done     = done_q;
    assign reseed_reject   = reject_q;
    assign sha_init        = (state_q == StLaunch);
    assign sha_clear_input = clear_q;
    assign blk_ack         = ack_q;
    assign key             = key_q;
    assign seeded          = seeded_q;
    assign reseed_cnt      = cnt_q;
    assign busy            = (state_q != StIdle);

endmodule

// File: doc/fortuna_reseed_ctrl.md
Name: fortuna_reseed_ctrl

Overview:
- Reseed controller directly downstream of sha256d, and also its driver.
- On a reseed request it forms the sha256d input as current key XOR seed material (256 bits) and launches sha256d.
- It captures the double hash as the new generator key and maintains the Fortuna 128-bit block counter C and the reseed count.
- It serves the AES generator with key, counter and a per-block counter-advance handshake.

Parameters:
- MIN_RESEED_CYCLES, 1000, minimum clk cycles between accepted reseeds (timer feature only).
- TIMER_W, 32, width of the reseed interval timer.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reseed_req  in  1  one-cycle request: seed_material valid
- seed_material  in  256  combined pool digests for this reseed
- reseed_done  out  1  one-cycle pulse: new key installed
- reseed_reject  out  1  one-cycle pulse: request dropped (busy or too early)
- sha_init  out  1  one-cycle start pulse to sha256d
- sha_clear_input  out  256  sha256d input, registered
- sha_ready  in  1  sha256d ready
- sha_hash  in  256  sha256d result
- sha_hash_valid  in  1  sha256d result valid
- blk_req  in  1  generator requests counter for one AES block
- blk_ack  out  1  one-cycle pulse: key/ctr valid for this block, ctr advances next cycle
- key  out  256  current generator key
- ctr  out  128  current counter C
- seeded  out  1  high once the first reseed completes (ctr != 0)
- reseed_cnt  out  32  number of completed reseeds, saturating
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - All outputs 0; key=0, ctr=0, reseed_cnt=0, seeded=0, sha_clear_input=0.
  - Timer reset to MIN_RESEED_CYCLES, so the first reseed is accepted immediately.
  - Reset mid-operation aborts the reseed; any later sha256d result is ignored because the FSM is back in IDLE.
- FSM states: IDLE, LAUNCH, WAIT_LOW, WAIT_HASH.
- IDLE:
  - reseed_req accepted only when sha_ready=1 and the timer has expired.
  - On accept: sha_clear_input <= key ^ seed_material, go to LAUNCH.
  - Otherwise the request is dropped with a reseed_reject pulse in the next cycle.
- LAUNCH: sha_init=1 for exactly this cycle, then go to WAIT_LOW.
- WAIT_LOW: wait for sha_ready=0, then go to WAIT_HASH. If sha_ready is still 1 after 4 cycles, go to WAIT_HASH anyway, to tolerate a core with zero-cycle deassert.
- WAIT_HASH: on sha_ready=1 and sha_hash_valid=1:
  - key <= sha_hash; ctr <= ctr+1; reseed_cnt <= reseed_cnt+1 (saturating at 2^32-1); seeded <= 1.
  - Timer cleared; reseed_done pulses the next cycle; return to IDLE.
- Reseed latency: accept → sha_init is 1 cycle; sha256d completion → key visible is 1 cycle.
- Any reseed_req while busy=1 → reseed_reject pulse; no state change.
- Block handshake:
  - In IDLE with seeded=1, blk_req → blk_ack the next cycle.
  - Generator samples key/ctr on the blk_ack cycle; ctr increments the cycle after.
  - Back-to-back blk_req gives 1 block per 2 cycles.
  - blk_req is ignored (no ack, not queued) while busy or unseeded; the generator must hold blk_req.
- Simultaneous reseed_req and blk_req in IDLE: reseed wins; blk_req waits.
- ctr arithmetic is modulo 2^128, but 2^128-1 + 1 → 1 (0 is reserved for "unseeded").
- key and ctr change only in the cycles stated above.

Optional Feature:
- RESEED_TIMER_EN defined:
  - TIMER_W up-counter, saturating at MIN_RESEED_CYCLES, cleared at each key install.
  - reseed_req before expiry → reseed_reject.
- Not defined: the timer logic is absent and reseeds are limited only by busy.

Decomposition:
- Package fortuna_pkg: KEY_W=256, CTR_W=128, RESEED_CNT_W=32, FSM state enum constants. The package is shared with the pool accumulator and the generator.
- One natural sub-module: fortuna_ctr128, a 128-bit counter with increment enable and skip-zero wrap.

Test Plan:
- Reset, then reseed_req with seed e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855 (key=0), sha256d model returning aa6ac2d4961882f42a345c7615f4133dde8e6d6e7c1b6b40ae4ff6ee52c393d0 → sha_clear_input = seed, one sha_init pulse, then key = aa6a…93d0, ctr=1, reseed_cnt=1, seeded=1, single reseed_done.
- blk_req held for 3 acks after the first reseed → blk_ack ×3 on alternating cycles with sampled ctr 1,2,3; ctr=4 afterwards.
- blk_req before any reseed for 20 cycles → no blk_ack, ctr stays 0.
- Second reseed_req while WAIT_HASH → reseed_reject pulse, key unchanged until the first completes; with RESEED_TIMER_EN and MIN_RESEED_CYCLES=10, a request 5 cycles after reseed_done → reject; at 10 cycles → accept, sha_clear_input = key ^ seed.
- Reset asserted in WAIT_HASH, then sha_hash_valid arrives → all outputs 0, key stays 0, no reseed_done.
- Force ctr = 2^128-1 and do one blk_ack → ctr = 1, seeded stays 1.
